// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 constants, receiver state encoding and parity helper
// for the keyboard decoder slice.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] DEF_KEY_LEFT   = 8'h6B;
  localparam logic [7:0] DEF_KEY_RIGHT  = 8'h74;
  localparam logic [7:0] DEF_KEY_FIRE   = 8'h29;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_ps2_rx.sv
// PS/2 frame receiver: pad synchronisers, clock glitch filter, frame
// deserialiser with parity/stop checking and an inter-bit timeout.
module ps2_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          sample_ev;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  // Two-flop synchronisers; the idle PS/2 bus is high, so they reset to 1.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Filtered clock only follows the synchronised clock after FILTER_LEN disagreeing samples in a row.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state plus a delayed copy used for falling-edge detection.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  assign sample_ev = filt_prev_q & ~filt_q;

  // Frame FSM advances on sample events; otherwise the timeout counter runs while mid-frame.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_cnt_d    = '0;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (sample_ev) begin
      case (state_q)
        RX_IDLE: begin
          if (!data_sync_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          par_d   = data_sync_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (odd_parity_ok(shift_q, par_q) && data_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = RX_IDLE;
        frame_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  // Receiver state, shift register, timeout counter and registered strobes.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_out   = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan-code traffic into level-held left/right/fire controls,
// tracking E0 (extended) and F0 (break) prefixes between codes.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int         FILTER_LEN     = 4,
  parameter int         TIMEOUT_CYCLES = 6500,
  parameter logic [7:0] KEY_LEFT       = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT      = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_FIRE       = DEF_KEY_FIRE
) (
  input  logic pclk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic left,
  output logic right,
  output logic fire,
  output logic frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       left_q, left_d, right_q, right_d, fire_q, fire_d;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .pclk       (pclk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  // Prefix flags stick until a non-prefix byte or a frame error; key levels follow make/break.
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    left_d  = left_q;
    right_d = right_q;
    fire_d  = fire_q;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q && (rx_byte == KEY_LEFT)) begin
          left_d = ~brk_q;
        end
        if (ext_q && (rx_byte == KEY_RIGHT)) begin
          right_d = ~brk_q;
        end
        if (!ext_q && (rx_byte == KEY_FIRE)) begin
          fire_d = ~brk_q;
        end
      end
    end
  end

  // Decoder flags and registered key outputs.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      left_q  <= left_d;
      right_q <= right_d;
      fire_q  <= fire_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign fire      = fire_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, hand-written
// corner sequences and a randomised run against a key-state model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int HALF = 20;
  localparam int TMO  = 6500;

  typedef struct {
    logic [7:0] code;
    bit         flip_par;
    bit         bad_stop;
    logic       exp_left;
    logic       exp_right;
    logic       exp_fire;
    int         exp_err;
  } vec_t;

  logic pclk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic left, right, fire, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  vec_t vecs[$];

  ps2_key_decoder dut (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .left      (left),
    .right     (right),
    .fire      (fire),
    .frame_err (frame_err)
  );

  // 100 MHz-style bench clock.
  always #5 pclk = ~pclk;

  // Count every cycle frame_err is high, so a single pulse shows as exactly one.
  always @(negedge pclk) begin
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] code, input bit fp, input bit bs,
                              input logic l, input logic r, input logic f, input int e);
    vec_t v;
    v.code = code; v.flip_par = fp; v.bad_stop = bs;
    v.exp_left = l; v.exp_right = r; v.exp_fire = f; v.exp_err = e;
    return v;
  endfunction

  // Frame bit 0 is the start bit, bits 1-8 data LSB first, bit 9 odd parity, bit 10 stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    logic par;
    par = ~(^b);
    if (flip_par) par = ~par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      @(posedge pclk); #1 ps2_data = fr[i];
      if (i == glitch_bit) begin
        repeat (5) @(posedge pclk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge pclk);
        #1 ps2_clk = 1'b1;
        repeat (HALF - 7) @(posedge pclk);
      end else begin
        repeat (HALF) @(posedge pclk);
      end
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge pclk);
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] code, input bit flip_par, input bit bad_stop);
    send_bits(make_frame(code, flip_par, bad_stop), 11, -1);
    repeat (30) @(posedge pclk);
  endtask

  task automatic check_keys(input string tag, input logic l, input logic r, input logic f);
    @(negedge pclk);
    check_output({tag, ".left"}, left, l);
    check_output({tag, ".right"}, right, r);
    check_output({tag, ".fire"}, fire, f);
  endtask

  task automatic print_summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Hard time limit so the bench always ends on its own.
  initial begin
    #2_000_000;
    n_bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    print_summary();
    $finish;
  end

  initial begin
    int e0;
    logic [7:0] pending[$];
    bit held[int];
    logic [7:0] code;
    bit flip, m_ext, m_rel;

    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h74, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(8'h6B, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(8'hE0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(8'h74, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'hFA, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h29, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h6B, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(8'h6B, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 0, 0, 0, 0));

    // Reset values while reset is held.
    repeat (5) @(posedge pclk);
    #1;
    check_output("reset.left", left, 0);
    check_output("reset.right", right, 0);
    check_output("reset.fire", fire, 0);
    check_output("reset.frame_err", frame_err, 0);
    rst = 1'b1;

    // Idle bus.
    e0 = err_seen;
    repeat (10000) @(posedge pclk);
    check_keys("idle", 0, 0, 0);
    check_output("idle.err", err_seen - e0, 0);

    // Vector table.
    foreach (vecs[i]) begin
      e0 = err_seen;
      apply_stimulus(vecs[i].code, vecs[i].flip_par, vecs[i].bad_stop);
      check_keys($sformatf("vec%0d", i), vecs[i].exp_left, vecs[i].exp_right, vecs[i].exp_fire);
      check_output($sformatf("vec%0d.err", i), err_seen - e0, vecs[i].exp_err);
    end

    // Latency: left rises 2 + FILTER_LEN + 2 pclk edges after the raw stop-bit clock fall.
    apply_stimulus(8'hE0, 0, 0);
    send_bits(make_frame(8'h6B, 0, 0), 10, -1);
    @(posedge pclk); #1 ps2_data = 1'b1;
    repeat (HALF) @(posedge pclk);
    #1 ps2_clk = 1'b0;
    repeat (7) @(posedge pclk);
    @(negedge pclk);
    check_output("latency.before", left, 0);
    @(posedge pclk);
    @(negedge pclk);
    check_output("latency.after", left, 1);
    repeat (HALF - 8) @(posedge pclk);
    #1 ps2_clk = 1'b1;
    repeat (30) @(posedge pclk);
    apply_stimulus(8'hE0, 0, 0);
    apply_stimulus(8'hF0, 0, 0);
    apply_stimulus(8'h6B, 0, 0);
    check_keys("release_left", 0, 0, 0);

    // Timeout on a partial frame clears pending prefixes.
    apply_stimulus(8'hE0, 0, 0);
    apply_stimulus(8'hF0, 0, 0);
    e0 = err_seen;
    send_bits(make_frame(8'h74, 0, 0), 4, -1);
    repeat (TMO + 500) @(posedge pclk);
    check_keys("timeout", 0, 0, 0);
    check_output("timeout.err", err_seen - e0, 1);
    apply_stimulus(8'h74, 0, 0);
    check_keys("after_timeout", 0, 0, 0);
    check_output("after_timeout.err", err_seen - e0, 1);

    // Short ps2_clk glitches inside frames are filtered out.
    e0 = err_seen;
    send_bits(make_frame(8'h29, 0, 0), 11, 4);
    repeat (30) @(posedge pclk);
    check_keys("glitch_make", 0, 0, 1);
    apply_stimulus(8'hF0, 0, 0);
    send_bits(make_frame(8'h29, 0, 0), 11, 9);
    repeat (30) @(posedge pclk);
    check_keys("glitch_break", 0, 0, 0);
    check_output("glitch.err", err_seen - e0, 0);

    // Asynchronous reset mid-frame drops held keys immediately.
    apply_stimulus(8'hE0, 0, 0);
    apply_stimulus(8'h6B, 0, 0);
    apply_stimulus(8'h29, 0, 0);
    check_keys("pre_reset", 1, 0, 1);
    send_bits(make_frame(8'h74, 0, 0), 5, -1);
    @(negedge pclk);
    rst = 1'b0;
    #1;
    check_output("async_reset.left", left, 0);
    check_output("async_reset.fire", fire, 0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
    repeat (100) @(posedge pclk);

    // Randomised traffic against a key-state model built from prefix history.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    code = 8'hE0;
        2:       code = 8'hF0;
        3:       code = 8'h6B;
        4:       code = 8'h74;
        5:       code = 8'h29;
        6:       code = 8'hFA;
        default: code = 8'($urandom_range(0, 255));
      endcase
      flip = ($urandom_range(0, 7) == 0);
      e0 = err_seen;
      apply_stimulus(code, flip, 0);
      if (flip) begin
        pending.delete();
      end else if (code == 8'hE0 || code == 8'hF0) begin
        pending.push_back(code);
      end else begin
        m_ext = 0;
        m_rel = 0;
        foreach (pending[j]) begin
          if (pending[j] == 8'hE0) m_ext = 1;
          if (pending[j] == 8'hF0) m_rel = 1;
        end
        held[int'(m_ext) * 256 + int'(code)] = !m_rel;
        pending.delete();
      end
      check_keys($sformatf("rand%0d", n),
                 held.exists(256 + 8'h6B) ? held[256 + 8'h6B] : 1'b0,
                 held.exists(256 + 8'h74) ? held[256 + 8'h74] : 1'b0,
                 held.exists(8'h29) ? held[8'h29] : 1'b0);
      check_output($sformatf("rand%0d.err", n), err_seen - e0, flip ? 1 : 0);
    end

    print_summary();
    $finish;
  end

endmodule
